// File: rtl/npc_pkg.sv
// Shared definitions for the NPC fetch path.
//   XLEN     : datapath and PC width
//   RESET_PC : PC loaded on reset
//   PC_STEP  : sequential instruction size in bytes
//   fetch_state_e : fetch/commit sequencer states
package npc_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int unsigned PC_STEP  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StTrap
  } fetch_state_e;

endpackage

// File: rtl/pc_next_adder.sv
// Next-PC target computation.
//   PC, Imm, Rs1     : operands
//   PCAsrc           : addend A select (0 = PC_STEP, 1 = Imm)
//   PCBsrc           : addend B select (0 = PC, 1 = Rs1); also marks the JALR form
//   Target           : computed next PC (sum modulo 2^XLEN, bit 0 cleared for JALR form)
//   Misaligned       : Target is not 4-byte aligned
module pc_next_adder
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = npc_pkg::XLEN
) (
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] Rs1,
  input  logic            PCAsrc,
  input  logic            PCBsrc,
  output logic [XLEN-1:0] Target,
  output logic            Misaligned
);

  logic [XLEN-1:0] addend_a;
  logic [XLEN-1:0] addend_b;
  logic [XLEN-1:0] sum;

  always_comb begin
    addend_a = PCAsrc ? Imm : XLEN'(PC_STEP);
    addend_b = PCBsrc ? Rs1 : PC;
    // Carry out is dropped: the PC wraps modulo 2^XLEN.
    sum      = addend_a + addend_b;
    Target   = PCBsrc ? {sum[XLEN-1:1], 1'b0} : sum;
    // With bit 0 already cleared for JALR, this reduces to target[1] in that form.
    Misaligned = |Target[1:0];
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Architectural PC owner and instruction-fetch sequencer.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   PCAsrc, PCBsrc, Imm, Rs1    : next-PC operands, valid with ExValid
//   ExValid                     : held instruction commits (honoured in HOLD only)
//   IfReqValid/Addr/Ready       : fetch request handshake
//   IfRspValid/Inst             : fetch response
//   InstValid, Inst, PC         : current instruction for decode
//   Fault, FaultPC              : sticky misaligned-target trap and offending target
module pc_fetch_ctrl #(
  parameter int unsigned      XLEN     = npc_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(npc_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCAsrc,
  input  logic            PCBsrc,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] Rs1,
  input  logic            ExValid,
  output logic            IfReqValid,
  output logic [XLEN-1:0] IfReqAddr,
  input  logic            IfReqReady,
  input  logic            IfRspValid,
  input  logic [31:0]     IfRspInst,
  output logic            InstValid,
  output logic [31:0]     Inst,
  output logic [XLEN-1:0] PC,
  output logic            Fault,
  output logic [XLEN-1:0] FaultPC
);

  import npc_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic [XLEN-1:0] target;
  logic            misaligned;

  pc_next_adder #(
    .XLEN (XLEN)
  ) u_pc_next_adder (
    .PC         (pc_q),
    .Imm        (Imm),
    .Rs1        (Rs1),
    .PCAsrc     (PCAsrc),
    .PCBsrc     (PCBsrc),
    .Target     (target),
    .Misaligned (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    case (state_q)
      StIdle: state_d = StReq;
      // A response arriving here belongs to no accepted request and is dropped.
      StReq: if (IfReqReady) state_d = StWait;
      StWait: begin
        if (IfRspValid) begin
          inst_d  = IfRspInst;
          state_d = StHold;
        end
      end
      StHold: begin
        if (ExValid) begin
          if (misaligned) begin
            fault_d    = 1'b1;
            fault_pc_d = target;
            state_d    = StTrap;
          end else begin
            pc_d    = target;
            state_d = StReq;
          end
        end
      end
      StTrap: state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign IfReqValid = (state_q == StReq);
  assign IfReqAddr  = pc_q;
  assign InstValid  = (state_q == StHold);
  assign Inst       = inst_q;
  assign PC         = pc_q;
  assign Fault      = fault_q;
  assign FaultPC    = fault_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        PCAsrc;
  logic        PCBsrc;
  logic [31:0] Imm;
  logic [31:0] Rs1;
  logic        ExValid;
  logic        IfReqValid;
  logic [31:0] IfReqAddr;
  logic        IfReqReady;
  logic        IfRspValid;
  logic [31:0] IfRspInst;
  logic        InstValid;
  logic [31:0] Inst;
  logic [31:0] PC;
  logic        Fault;
  logic [31:0] FaultPC;

  int vectors;
  int miscompares;

  pc_fetch_ctrl #(
    .XLEN     (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCAsrc     (PCAsrc),
    .PCBsrc     (PCBsrc),
    .Imm        (Imm),
    .Rs1        (Rs1),
    .ExValid    (ExValid),
    .IfReqValid (IfReqValid),
    .IfReqAddr  (IfReqAddr),
    .IfReqReady (IfReqReady),
    .IfRspValid (IfRspValid),
    .IfRspInst  (IfRspInst),
    .InstValid  (InstValid),
    .Inst       (Inst),
    .PC         (PC),
    .Fault      (Fault),
    .FaultPC    (FaultPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From REQ: accept the request, then return inst on the following cycle -> HOLD.
  task automatic fetch(input logic [31:0] inst);
    IfReqReady = 1'b1;
    step();
    check("fetch_accept_reqvalid", 32'(IfReqValid), 32'd0);
    IfReqReady = 1'b0;
    IfRspValid = 1'b1;
    IfRspInst  = inst;
    step();
    IfRspValid = 1'b0;
    check("fetch_instvalid", 32'(InstValid), 32'd1);
    check("fetch_inst", Inst, inst);
  endtask

  task automatic commit(input logic a, input logic b, input logic [31:0] imm,
                        input logic [31:0] rs1);
    PCAsrc  = a;
    PCBsrc  = b;
    Imm     = imm;
    Rs1     = rs1;
    ExValid = 1'b1;
    step();
    ExValid = 1'b0;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    check({tag, "_reqvalid"}, 32'(IfReqValid), 32'd1);
    check({tag, "_reqaddr"}, IfReqAddr, addr);
    check({tag, "_pc"}, PC, addr);
    check({tag, "_instvalid"}, 32'(InstValid), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset with random inputs.
    rst_n      = 1'b0;
    PCAsrc     = 1'($urandom);
    PCBsrc     = 1'($urandom);
    Imm        = $urandom;
    Rs1        = $urandom;
    ExValid    = 1'($urandom);
    IfReqReady = 1'($urandom);
    IfRspValid = 1'($urandom);
    IfRspInst  = $urandom;
    step();
    step();
    check("rst_pc", PC, 32'h8000_0000);
    check("rst_reqvalid", 32'(IfReqValid), 32'd0);
    check("rst_reqaddr", IfReqAddr, 32'h8000_0000);
    check("rst_instvalid", 32'(InstValid), 32'd0);
    check("rst_inst", Inst, 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    check("rst_faultpc", FaultPC, 32'd0);

    ExValid    = 1'b0;
    IfReqReady = 1'b0;
    IfRspValid = 1'b0;
    rst_n      = 1'b1;
    #1;
    check("idle_reqvalid", 32'(IfReqValid), 32'd0);
    step();
    expect_req("first_req", 32'h8000_0000);

    // Backpressure: request stays stable, stray response and ExValid ignored.
    for (int i = 0; i < 3; i++) begin
      IfRspValid = (i == 1);
      IfRspInst  = 32'hDEAD_BEEF;
      ExValid    = (i == 2);
      PCAsrc     = 1'b1;
      Imm        = 32'h100;
      step();
      check("bp_reqvalid", 32'(IfReqValid), 32'd1);
      check("bp_reqaddr", IfReqAddr, 32'h8000_0000);
      check("bp_instvalid", 32'(InstValid), 32'd0);
    end
    ExValid = 1'b0;

    // Response coincident with acceptance is dropped; WAIT then holds.
    IfReqReady = 1'b1;
    IfRspValid = 1'b1;
    step();
    IfReqReady = 1'b0;
    IfRspValid = 1'b0;
    check("acc_reqvalid", 32'(IfReqValid), 32'd0);
    check("acc_instvalid", 32'(InstValid), 32'd0);
    step();
    check("wait_instvalid", 32'(InstValid), 32'd0);
    IfRspValid = 1'b1;
    IfRspInst  = 32'h0000_0013;
    step();
    check("rsp_instvalid", 32'(InstValid), 32'd1);
    check("rsp_inst", Inst, 32'h0000_0013);

    // HOLD without ExValid keeps the instruction; a late response is ignored.
    IfRspInst = 32'hDEAD_BEEF;
    step();
    IfRspValid = 1'b0;
    check("hold_instvalid", 32'(InstValid), 32'd1);
    check("hold_inst", Inst, 32'h0000_0013);
    check("hold_reqvalid", 32'(IfReqValid), 32'd0);

    // Sequential step.
    commit(1'b0, 1'b0, 32'h1234_5678, 32'h0000_0003);
    expect_req("seq", 32'h8000_0004);

    // Forward branch to 0x80000010, then backward branch.
    fetch(32'h0000_0063);
    commit(1'b1, 1'b0, 32'h0000_000C, 32'hFFFF_FFFF);
    expect_req("fwd", 32'h8000_0010);
    fetch(32'hFE00_0CE3);
    commit(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0000);
    expect_req("back", 32'h8000_0008);

    // JALR: 0x80001001 + 4 = 0x80001005, bit 0 cleared.
    fetch(32'h0040_80E7);
    commit(1'b1, 1'b1, 32'h0000_0004, 32'h8000_1001);
    expect_req("jalr", 32'h8000_1004);

    // PCAsrc=0, PCBsrc=1: Rs1 + 4 with bit 0 cleared.
    fetch(32'h0000_0013);
    commit(1'b0, 1'b1, 32'h7777_7777, 32'h8000_2001);
    expect_req("rs1p4", 32'h8000_2004);

    // Wrap-around: 0xFFFFFFFC + 4 -> 0.
    fetch(32'h0000_0013);
    commit(1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC);
    expect_req("to_top", 32'hFFFF_FFFC);
    fetch(32'h0000_0013);
    commit(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    expect_req("wrap", 32'h0000_0000);

    // Reset asserted while in WAIT.
    IfReqReady = 1'b1;
    step();
    IfReqReady = 1'b0;
    check("mid_wait_reqvalid", 32'(IfReqValid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", PC, 32'h8000_0000);
    check("mid_rst_reqvalid", 32'(IfReqValid), 32'd0);
    check("mid_rst_inst", Inst, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    expect_req("restart", 32'h8000_0000);

    // Misaligned branch target traps.
    fetch(32'h0000_0063);
    commit(1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000);
    check("mis_fault", 32'(Fault), 32'd1);
    check("mis_faultpc", FaultPC, 32'h8000_0006);
    check("mis_pc", PC, 32'h8000_0000);
    check("mis_reqvalid", 32'(IfReqValid), 32'd0);
    check("mis_instvalid", 32'(InstValid), 32'd0);

    // TRAP ignores everything for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      ExValid    = i[0];
      PCAsrc     = 1'b0;
      PCBsrc     = 1'b0;
      IfReqReady = 1'b1;
      IfRspValid = ~i[0];
      IfRspInst  = 32'h1111_1111;
      step();
      check("trap_reqvalid", 32'(IfReqValid), 32'd0);
      check("trap_instvalid", 32'(InstValid), 32'd0);
      check("trap_pc", PC, 32'h8000_0000);
      check("trap_faultpc", FaultPC, 32'h8000_0006);
    end
    ExValid    = 1'b0;
    IfReqReady = 1'b0;
    IfRspValid = 1'b0;

    // JALR misalignment: 0x80000002 + 0 -> bit 1 set.
    rst_n = 1'b0;
    step();
    check("rst2_fault", 32'(Fault), 32'd0);
    rst_n = 1'b1;
    step();
    expect_req("restart2", 32'h8000_0000);
    fetch(32'h0000_8067);
    commit(1'b1, 1'b1, 32'h0000_0000, 32'h8000_0002);
    check("jmis_fault", 32'(Fault), 32'd1);
    check("jmis_faultpc", FaultPC, 32'h8000_0002);
    check("jmis_pc", PC, 32'h8000_0000);
    check("jmis_reqvalid", 32'(IfReqValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
